fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter SIZE, default 8, data width of one FIFO word and of one serial frame payload.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be >= 2.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 buf_out  input  SIZE  FIFO read data, valid the cycle after read_en is high.
REQ-006 buf_empty  input  1  FIFO empty flag.
REQ-007 tx_enable  input  1  permits starting new frames.
REQ-008 read_en  output  1  FIFO pop request, registered, one-cycle pulse.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  one-cycle pulse after the last STOP cycle.

Function
REQ-012 States: IDLE, POP, LOAD, START, DATA, PARITY (only with PARITY_EN), STOP.
REQ-013 IDLE -> POP when tx_enable=1 and buf_empty=0 at the clock edge; otherwise stay in IDLE.
REQ-014 POP: read_en=1 for exactly this one cycle; next state LOAD.
REQ-015 LOAD: buf_out captured into the shift register at the end of this cycle; next state START; tx=1.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA: SIZE bits, LSB first, each held CLKS_PER_BIT cycles.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; on exit, frame_done=1 for one cycle and the state returns to IDLE.
REQ-019 Baud counter width $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
REQ-020 Bit counter width $clog2(SIZE); it wraps to 0 when leaving DATA.
REQ-021 Frame length is (SIZE+2)*CLKS_PER_BIT cycles; back-to-back frames add 3 high cycles (IDLE, POP, LOAD).
REQ-022 read_en SHALL never be high in a cycle following a sampled buf_empty=1.
REQ-023 tx_enable deasserting mid-frame SHALL NOT truncate the frame; it only blocks the next IDLE->POP.
REQ-024 buf_empty changing mid-frame SHALL have no effect until IDLE.

Reset
REQ-025 On rst=1 at an edge: state=IDLE, tx=1, read_en=0, busy=0, frame_done=0, and all counters and the shift register cleared.
REQ-026 Reset mid-frame SHALL abort the frame without a frame_done pulse; the popped word is discarded.

Configuration
REQ-027 Macro FIFO_UART_TX_PARITY_EN defined: a PARITY state follows DATA and drives the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles; the frame becomes (SIZE+3)*CLKS_PER_BIT cycles.
REQ-028 Macro not defined: no PARITY state, and STOP follows DATA directly.

Structure
REQ-029 The shared package fifo_uart_pkg SHALL hold the state enum typedef and the default SIZE/CLKS_PER_BIT constants.
REQ-030 One sub-module, baud_tick_gen, SHALL provide the CLKS_PER_BIT counter and a bit-tick pulse, cleared by the FSM on frame start.

Verification (SIZE=8, CLKS_PER_BIT=4)
REQ-031 Reset: hold rst for 3 cycles -> tx=1, read_en=0, busy=0, frame_done=0.
REQ-032 Single word: buf_out=0xA5, buf_empty=0 for one pop, tx_enable=1 -> one read_en pulse; then tx=0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total); one frame_done pulse.
REQ-033 Back-to-back: 0x00 then 0xFF with buf_empty=0 -> read_en pulses 43 cycles apart; second payload all ones.
REQ-034 Enable drop: tx_enable=0 during DATA with buf_empty=0 -> the current frame completes, then no read_en and busy=0.
REQ-035 Reset mid-DATA: rst at the 3rd data bit -> tx=1 and busy=0 next cycle; no frame_done.
REQ-036 With FIFO_UART_TX_PARITY_EN: buf_out=0x07 -> parity bit 1; frame length 44 cycles.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and default sizes for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state encoding.
package fifo_uart_pkg;

  localparam int SIZE_DEF         = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_tick_o = (cnt_q == LAST) && !clear_i;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word, sends START, SIZE data bits LSB first, STOP.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line high, waiting for tx_enable and a non-empty FIFO
// POP    | read_en pulse
// LOAD   | capture buf_out into the shift register
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | even parity of the payload (optional)
// STOP   | stop bit (high), frame_done follows
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] buf_out,
  input  logic            buf_empty,
  input  logic            tx_enable,
  output logic            read_en,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic            read_en_q, read_en_d;
  logic            done_q, done_d;
  logic            bit_tick;
  logic            baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Counter is held at zero outside the bit-timed states so START is always full length.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (baud_clear),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE:  if (tx_enable && !buf_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = buf_out;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^buf_out;
`endif
        state_d = ST_START;
      end
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    read_en_d = (state_d == ST_POP);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      read_en_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      read_en_q <= read_en_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign read_en    = read_en_q;
  assign tx         = tx_q;
  assign frame_done = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds words, a serial monitor rebuilds each frame
// and compares it against the word popped for it.
module tb_fifo_uart_tx;

  localparam int SIZE = 8;
  localparam int CPB  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_CYC = (SIZE + 3) * CPB;
`else
  localparam int FRAME_CYC = (SIZE + 2) * CPB;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] buf_out;
  logic            buf_empty;
  logic            tx_enable;
  logic            read_en, tx, busy, frame_done;

  fifo_uart_tx #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .buf_out    (buf_out),
    .buf_empty  (buf_empty),
    .tx_enable  (tx_enable),
    .read_en    (read_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_done = 0;
  int n_frames = 0;
  int last_rd = 0;
  int mon_cnt = 0;
  bit mon_act = 1'b0;
  bit done_due = 1'b0;
  logic [SIZE-1:0] fifo[$];
  logic [SIZE-1:0] exp_q[$];
  int rd_hist[$];
  logic [63:0] obs_vec, exp_vec;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] build_frame(input logic [SIZE-1:0] w);
    logic [63:0] v;
    int b;
    v = '0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      b = i / CPB;
      if (b == 0)                         v[i] = 1'b0;
      else if (b <= SIZE)                 v[i] = w[b-1];
      else if (b == FRAME_CYC / CPB - 1)  v[i] = 1'b1;
      else                                v[i] = ^w;
    end
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears after the cycle in which read_en is seen high
  initial begin
    logic [SIZE-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (read_en) begin
        n_pop++;
        last_rd = cyc;
        rd_hist.push_back(cyc);
        if (fifo.size() == 0) begin
          check("pop_empty", 64'd1, 64'd0);
        end else begin
          w = fifo.pop_front();
          buf_out = w;
          exp_q.push_back(w);
        end
        buf_empty = (fifo.size() == 0);
      end
    end
  end

  // Serial monitor
  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (rst) begin
      mon_act = 1'b0;
      done_due = 1'b0;
      exp_q.delete();
    end else begin
      if (done_due) begin
        check("frame_done", 64'(frame_done), 64'd1);
        done_due = 1'b0;
      end
      if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
          obs_vec = '0;
          obs_vec[0] = tx;
          check("start_lat", 64'(cyc - last_rd), 64'd2);
          if (exp_q.size() == 0) begin
            check("unexp_frame", 64'd1, 64'd0);
            exp_vec = '1;
          end else begin
            exp_vec = build_frame(exp_q.pop_front());
          end
        end
      end else begin
        mon_cnt++;
        obs_vec[mon_cnt] = tx;
        if (mon_cnt == FRAME_CYC - 1) begin
          mon_act = 1'b0;
          n_frames++;
          done_due = 1'b1;
          check("frame_bits", obs_vec, exp_vec);
        end
      end
    end
  end

  task automatic push_word(input logic [SIZE-1:0] w);
    @(posedge clk);
    #2;
    fifo.push_back(w);
    buf_empty = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_done < target; i++) @(negedge clk);
    check(tag, 64'(n_done), 64'(target));
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    tx_enable = 1'b0;
    buf_empty = 1'b1;
    buf_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_read_en", 64'(read_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single word
    tx_enable = 1'b1;
    push_word(8'hA5);
    wait_done(1, 200, "done_a5");
    check("pops_a5", 64'(n_pop), 64'd1);

    // back-to-back
    rd_hist.delete();
    push_word(8'h00);
    push_word(8'hFF);
    wait_done(3, 300, "done_b2b");
    check("b2b_pops", 64'(rd_hist.size()), 64'd2);
    if (rd_hist.size() == 2)
      check("b2b_gap", 64'(rd_hist[1] - rd_hist[0]), 64'(FRAME_CYC + 3));

    // enable dropped mid-frame with another word waiting
    p0 = n_pop;
    push_word(8'h3C);
    push_word(8'h81);
    for (int i = 0; i < 100 && !(mon_act && mon_cnt >= 8); i++) @(negedge clk);
    @(posedge clk);
    #1 tx_enable = 1'b0;
    wait_done(4, 200, "done_drop");
    repeat (60) @(negedge clk);
    check("drop_pops", 64'(n_pop), 64'(p0 + 1));
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_fifo", 64'(fifo.size()), 64'd1);
    @(posedge clk);
    #2;
    fifo.delete();
    buf_empty = 1'b1;

    // word waiting while disabled, then enabled (parity word when built with parity)
    p0 = n_pop;
    push_word(8'h07);
    repeat (10) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_pops", 64'(n_pop), 64'(p0));
    tx_enable = 1'b1;
    wait_done(5, 200, "done_07");

    // reset in the third data bit
    push_word(8'h5A);
    for (int i = 0; i < 100 && !(mon_act && mon_cnt >= 11); i++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'd5);

    // clean frame after the abort
    push_word(8'h96);
    wait_done(6, 200, "done_96");
    repeat (3) @(negedge clk);
    check("done_count", 64'(n_done), 64'(n_frames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
